// File: rtl/unsigned_multiply_arbiter.sv
// unsigned_multiply_arbiter: round-robin front end that shares one
// external unsigned multiplier and returns products over a handshake.
module unsigned_multiply_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     busy
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   win;
  logic              any;
  logic              cnt_done;
  logic              last_id;
  int                idx;

  // Descending scan so the lowest offset from ptr is written last.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        win = ID_W'(idx);
        any = 1'b1;
      end
    end
  end

  assign cnt_done = (cnt == CNT_W'(MUL_LAT - 1));
  assign last_id  = (rsp_id == ID_W'(NUM_REQ - 1));
  assign busy     = (state != IDLE);

  // Gated by rst_n so no grant is shown while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any && rst_n) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any) state_nx = CALC;
      CALC: if (cnt_done) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (any) begin
            mul_a  <= req_a[int'(win)*WIDTH +: WIDTH];
            mul_b  <= req_b[int'(win)*WIDTH +: WIDTH];
            rsp_id <= win;
            cnt    <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt_done) begin
            rsp_data  <= mul_p;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= last_id ? '0 : rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_multiply_arbiter.sv
// tb_unsigned_multiply_arbiter: randomized and directed checks of the
// shared-multiplier arbiter against a transaction-level model.
module tb_unsigned_multiply_arbiter;

  localparam int N0 = 4;
  localparam int W0 = 5;
  localparam int L0 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: defaults
  logic        rst0_n;
  logic [3:0]  v0, rdy0;
  logic [19:0] a0, b0;
  logic [4:0]  ma0, mb0;
  logic [9:0]  p0, rd0;
  logic        rv0, rr0, busy0;
  logic [1:0]  rid0;
  assign p0 = ma0 * mb0;

  unsigned_multiply_arbiter u0 (
    .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_a(a0), .req_b(b0),
    .req_ready(rdy0), .mul_a(ma0), .mul_b(mb0), .mul_p(p0),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_id(rid0), .rsp_data(rd0),
    .busy(busy0)
  );

  // dut1: MUL_LAT=3
  logic        rst1_n;
  logic [3:0]  v1, rdy1;
  logic [19:0] a1, b1;
  logic [4:0]  ma1, mb1;
  logic [9:0]  p1, rd1;
  logic        rv1, rr1, busy1;
  logic [1:0]  rid1;
  assign p1 = ma1 * mb1;

  unsigned_multiply_arbiter #(.NUM_REQ(4), .WIDTH(5), .MUL_LAT(3)) u1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_a(a1), .req_b(b1),
    .req_ready(rdy1), .mul_a(ma1), .mul_b(mb1), .mul_p(p1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_id(rid1), .rsp_data(rd1),
    .busy(busy1)
  );

  // dut2: NUM_REQ=3, WIDTH=8, MUL_LAT=2
  logic        rst2_n;
  logic [2:0]  v2, rdy2;
  logic [23:0] a2, b2;
  logic [7:0]  ma2, mb2;
  logic [15:0] p2, rd2;
  logic        rv2, rr2, busy2;
  logic [1:0]  rid2;
  assign p2 = ma2 * mb2;

  unsigned_multiply_arbiter #(.NUM_REQ(3), .WIDTH(8), .MUL_LAT(2)) u2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ready(rdy2), .mul_a(ma2), .mul_b(mb2), .mul_p(p2),
    .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(rid2), .rsp_data(rd2),
    .busy(busy2)
  );

  // transaction-level model of dut0
  int         m_ptr, m_timer, m_id;
  bit         m_busy, m_rsp, rv0_q, auto_drop;
  logic [4:0] m_a, m_b;
  logic [9:0] m_prod;
  int obs_id[$], obs_data[$], acc_cyc[$], rise_cyc[$];

  task automatic model_reset0();
    m_ptr = 0; m_timer = 0; m_id = 0;
    m_busy = 0; m_rsp = 0; rv0_q = 0;
    m_a = '0; m_b = '0; m_prod = '0;
  endtask

  task automatic clear_obs();
    obs_id.delete(); obs_data.delete();
    acc_cyc.delete(); rise_cyc.delete();
  endtask

  task automatic step0();
    logic [3:0] er;
    int w, idx;
    @(negedge clk);
    er = '0;
    w = -1;
    if (rst0_n && !m_busy)
      for (int k = 0; k < N0; k++) begin
        idx = (m_ptr + k) % N0;
        if (w < 0 && v0[idx]) w = idx;
      end
    if (w >= 0) er[w] = 1'b1;
    checks += 7;
    if (rdy0 !== er)
      begin errs++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, rdy0, er); end
    if (rv0 !== m_rsp)
      begin errs++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rv0, m_rsp); end
    if (busy0 !== m_busy)
      begin errs++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy0, m_busy); end
    if (rid0 !== 2'(m_id))
      begin errs++; $display("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, rid0, m_id); end
    if (rd0 !== m_prod)
      begin errs++; $display("FAIL rsp_data cyc=%0d got=%0d exp=%0d", cyc, rd0, m_prod); end
    if (ma0 !== m_a)
      begin errs++; $display("FAIL mul_a cyc=%0d got=%0d exp=%0d", cyc, ma0, m_a); end
    if (mb0 !== m_b)
      begin errs++; $display("FAIL mul_b cyc=%0d got=%0d exp=%0d", cyc, mb0, m_b); end
    if (rdy0 != 0) acc_cyc.push_back(cyc);
    if (rv0 && !rv0_q) rise_cyc.push_back(cyc);
    rv0_q = rv0;
    if (rv0 && rr0) begin
      obs_id.push_back(int'(rid0));
      obs_data.push_back(int'(rd0));
    end
    if (rst0_n) begin
      if (w >= 0) begin
        m_busy = 1; m_id = w; m_timer = L0;
        m_a = a0[w*W0 +: W0];
        m_b = b0[w*W0 +: W0];
      end else if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) begin
          m_rsp = 1;
          m_prod = 10'(m_a) * 10'(m_b);
        end
      end else if (m_rsp && rr0) begin
        m_rsp = 0; m_busy = 0;
        m_ptr = (m_id + 1) % N0;
      end
    end
    @(posedge clk); #1;
    if (auto_drop && w >= 0) v0[w] = 1'b0;
  endtask

  task automatic reset0();
    rst0_n = 1'b0;
    model_reset0();
    repeat (2) step0();
    rst0_n = 1'b1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    model_reset0();
    v0 = 4'($urandom); a0 = 20'($urandom); b0 = 20'($urandom);
    rr0 = 1'($urandom);
    repeat (2) step0();
    checks++;
    if ({rdy0, rv0, busy0, rid0, rd0, ma0, mb0} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rdy0, rv0, busy0, rid0, rd0, ma0, mb0});
    end
    v0 = '0;
    rst0_n = 1'b1;
    repeat (3) step0();
    checks++;
    if (rdy0 !== 4'b0 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL reset_release rdy=%b busy=%b exp 0/0", rdy0, busy0);
    end
  endtask

  task automatic test_single();
    v0 = '0;
    reset0();
    auto_drop = 1; rr0 = 1'b1;
    clear_obs();
    a0 = 20'($urandom); b0 = 20'($urandom);
    a0[10 +: 5] = 5'd31; b0[10 +: 5] = 5'd31;
    v0 = 4'b0100;
    repeat (8) step0();
    checks++;
    if (acc_cyc.size() != 1) begin
      errs++; $display("FAIL single_accepts got=%0d exp=1", acc_cyc.size());
    end
    checks++;
    if (obs_id.size() != 1 || obs_id[0] != 2 || obs_data[0] != 961) begin
      errs++;
      $display("FAIL single_rsp n=%0d id=%0d data=%0d exp id=2 data=961",
               obs_id.size(), obs_id[0], obs_data[0]);
    end
    checks++;
    if (rise_cyc.size() != 1 || rise_cyc[0] - acc_cyc[0] != L0 + 1) begin
      errs++;
      $display("FAIL single_latency got=%0d exp=%0d",
               rise_cyc[0] - acc_cyc[0], L0 + 1);
    end
  endtask

  task automatic test_round_robin();
    v0 = '0;
    reset0();
    auto_drop = 0; rr0 = 1'b1;
    for (int i = 0; i < N0; i++) begin
      a0[i*W0 +: W0] = W0'(i + 1);
      b0[i*W0 +: W0] = W0'(3);
    end
    clear_obs();
    v0 = 4'b1111;
    repeat (16) step0();
    checks++;
    if (obs_id.size() < 5) begin
      errs++; $display("FAIL rr_count got=%0d exp>=5", obs_id.size());
    end
    for (int k = 0; k < 5 && k < obs_id.size(); k++) begin
      checks++;
      if (obs_id[k] != k % 4 || obs_data[k] != (k % 4 + 1) * 3) begin
        errs++;
        $display("FAIL rr_order k=%0d got id=%0d data=%0d exp id=%0d data=%0d",
                 k, obs_id[k], obs_data[k], k % 4, (k % 4 + 1) * 3);
      end
    end
    for (int k = 1; k < 5 && k < acc_cyc.size(); k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] != L0 + 2) begin
        errs++;
        $display("FAIL rr_spacing k=%0d got=%0d exp=%0d",
                 k, acc_cyc[k] - acc_cyc[k-1], L0 + 2);
      end
    end
    v0 = '0;
    repeat (4) step0();
  endtask

  task automatic test_backpressure();
    int n;
    v0 = '0;
    reset0();
    auto_drop = 1; rr0 = 1'b0;
    a0[5 +: 5] = 5'd7; b0[5 +: 5] = 5'd9;
    v0 = 4'b0010;
    n = 0;
    while (!rv0 && n < 10) begin step0(); n++; end
    checks++;
    if (!rv0) begin errs++; $display("FAIL bp_timeout rsp_valid=%b exp=1", rv0); end
    v0[0] = 1'b1; v0[3] = 1'b1;
    a0[0 +: 5] = 5'd2; b0[0 +: 5] = 5'd3;
    a0[15 +: 5] = 5'd4; b0[15 +: 5] = 5'd5;
    repeat (5) begin
      step0();
      checks++;
      if (rv0 !== 1'b1 || rid0 !== 2'd1 || rd0 !== 10'd63 || rdy0 !== 4'b0) begin
        errs++;
        $display("FAIL bp_hold v=%b id=%0d data=%0d rdy=%b exp 1/1/63/0000",
                 rv0, rid0, rd0, rdy0);
      end
    end
    clear_obs();
    rr0 = 1'b1;
    step0();
    checks++;
    if (obs_id.size() != 1 || obs_data[0] != 63 || busy0 !== 1'b0) begin
      errs++;
      $display("FAIL bp_release n=%0d data=%0d busy=%b exp 1/63/0",
               obs_id.size(), obs_data[0], busy0);
    end
    repeat (10) step0();
  endtask

  task automatic test_random();
    auto_drop = 1;
    clear_obs();
    repeat (600) begin
      for (int i = 0; i < N0; i++) begin
        if (!v0[i] && $urandom_range(3) == 0) begin
          v0[i] = 1'b1;
          a0[i*W0 +: W0] = W0'($urandom);
          b0[i*W0 +: W0] = W0'($urandom);
        end else if (v0[i] && $urandom_range(15) == 0) begin
          v0[i] = 1'b0;
        end
      end
      rr0 = ($urandom_range(2) != 0);
      step0();
    end
    v0 = '0; rr0 = 1'b1;
    repeat (6) step0();
    checks++;
    if (obs_id.size() < 20) begin
      errs++; $display("FAIL random_throughput got=%0d exp>=20", obs_id.size());
    end
  endtask

  task automatic test_reset_mid_calc();
    int n;
    bit early;
    rst1_n = 1'b0; v1 = '0; a1 = '0; b1 = '0; rr1 = 1'b1;
    @(posedge clk); #1;
    rst1_n = 1'b1;
    a1[5 +: 5] = 5'd1; b1[5 +: 5] = 5'd1;
    v1 = 4'b0010;
    #1;
    checks++;
    if (rdy1 !== 4'b0010) begin
      errs++; $display("FAIL mc_first_grant got=%b exp=0010", rdy1);
    end
    @(posedge clk); #1;
    v1 = '0;
    n = 0;
    while (!rv1 && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0) begin errs++; $display("FAIL mc_idle busy=%b exp=0", busy1); end
    a1[0 +: 5] = 5'd5; b1[0 +: 5] = 5'd7;
    a1[15 +: 5] = 5'd2; b1[15 +: 5] = 5'd2;
    v1 = 4'b1001;
    #1;
    checks++;
    if (rdy1 !== 4'b1000) begin
      errs++; $display("FAIL mc_ptr_grant got=%b exp=1000", rdy1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b1 || ma1 !== 5'd2) begin
      errs++; $display("FAIL mc_accept busy=%b mul_a=%0d exp 1/2", busy1, ma1);
    end
    @(posedge clk); #1;
    rst1_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({rdy1, rv1, busy1, rid1, rd1, ma1, mb1} !== '0) begin
        errs++;
        $display("FAIL mc_in_reset got=%h exp=0",
                 {rdy1, rv1, busy1, rid1, rd1, ma1, mb1});
      end
    end
    @(posedge clk); #1;
    rst1_n = 1'b1;
    #1;
    checks++;
    if (rdy1 !== 4'b0001) begin
      errs++; $display("FAIL mc_regrant got=%b exp=0001", rdy1);
    end
    n = 0; early = 0;
    while (!rv1 && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) v1[0] = 1'b0;
    end
    v1 = '0;
    checks++;
    if (n != 4 || rid1 !== 2'd0 || rd1 !== 10'd35) begin
      errs++;
      $display("FAIL mc_rsp edges=%0d id=%0d data=%0d exp 4/0/35", n, rid1, rd1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    int gid[$], rid[$], rdat[$], gcy[$], rcy[$];
    int eid[3], edat[3];
    logic [2:0] gr;
    bit rvq;
    eid[0] = 1; eid[1] = 2; eid[2] = 0;
    edat[0] = 65025; edat[1] = 12; edat[2] = 30;
    rst2_n = 1'b0; v2 = '0; a2 = '0; b2 = '0; rr2 = 1'b1;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    a2[8 +: 8] = 8'd255; b2[8 +: 8] = 8'd255;
    a2[16 +: 8] = 8'd3; b2[16 +: 8] = 8'd4;
    v2 = 3'b110;
    rvq = 0;
    for (int t = 0; t < 40 && rid.size() < 3; t++) begin
      @(negedge clk);
      gr = rdy2;
      if (gr != 0) begin
        gcy.push_back(t);
        for (int i = 0; i < 3; i++) if (gr[i]) gid.push_back(i);
      end
      if (rv2 && !rvq) rcy.push_back(t);
      rvq = rv2;
      if (rv2 && rr2) begin
        rid.push_back(int'(rid2));
        rdat.push_back(int'(rd2));
      end
      @(posedge clk); #1;
      if (gr[1]) begin
        v2[1] = 1'b0; v2[0] = 1'b1;
        a2[0 +: 8] = 8'd5; b2[0 +: 8] = 8'd6;
      end else if (gr != 0) begin
        v2 = v2 & ~gr;
      end
    end
    v2 = '0;
    checks++;
    if (rid.size() != 3 || gid.size() != 3) begin
      errs++;
      $display("FAIL wrap_count rsp=%0d grants=%0d exp 3/3", rid.size(), gid.size());
    end
    for (int k = 0; k < 3 && k < rid.size() && k < gid.size(); k++) begin
      checks++;
      if (gid[k] != eid[k] || rid[k] != eid[k] || rdat[k] != edat[k]) begin
        errs++;
        $display("FAIL wrap_order k=%0d grant=%0d id=%0d data=%0d exp id=%0d data=%0d",
                 k, gid[k], rid[k], rdat[k], eid[k], edat[k]);
      end
      checks++;
      if (k >= rcy.size() || k >= gcy.size() || rcy[k] - gcy[k] != 3) begin
        errs++;
        $display("FAIL wrap_latency k=%0d got=%0d exp=3", k, rcy[k] - gcy[k]);
      end
    end
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
    v0 = '0; a0 = '0; b0 = '0; rr0 = 1'b0;
    v1 = '0; a1 = '0; b1 = '0; rr1 = 1'b0;
    v2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
    auto_drop = 1;
    model_reset0();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid_calc();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
